// File: rtl/dram_fifo_ctl.sv
// Synchronous FIFO over a distributed-RAM array whose registered read port
// doubles as the output stage; DEPTH need not be a power of two.
module dram_fifo_ctl #(
  parameter int ADDRESSWIDTH = 6,
  parameter int BITWIDTH     = 1,
  parameter int DEPTH        = 34
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    wr_valid,
  output logic                    wr_ready,
  input  logic [BITWIDTH-1:0]     wr_data,
  output logic                    rd_valid,
  input  logic                    rd_ready,
  output logic [BITWIDTH-1:0]     rd_data,
  output logic [ADDRESSWIDTH:0]   level,
  output logic                    overflow_err
);

  localparam logic [ADDRESSWIDTH:0]   FULL_CNT = (ADDRESSWIDTH+1)'(DEPTH);
  localparam logic [ADDRESSWIDTH-1:0] LAST_PTR = ADDRESSWIDTH'(DEPTH-1);

  logic [BITWIDTH-1:0]     ram [DEPTH];
  logic [ADDRESSWIDTH-1:0] wr_ptr, rd_ptr;
  logic [ADDRESSWIDTH:0]   ram_cnt;
  logic                    wr_fire, load;

  // Pointers wrap at DEPTH-1 rather than at the binary boundary.
  function automatic logic [ADDRESSWIDTH-1:0] ptr_inc(input logic [ADDRESSWIDTH-1:0] p);
    return (p == LAST_PTR) ? '0 : p + 1'b1;
  endfunction

  assign wr_ready = (ram_cnt != FULL_CNT);
  assign wr_fire  = wr_valid & wr_ready;
  assign load     = (ram_cnt != '0) & (~rd_valid | rd_ready);
  assign level    = ram_cnt + {{ADDRESSWIDTH{1'b0}}, rd_valid};

  // Array carries no reset so it maps onto LUT RAM.
  always_ff @(posedge clk) begin
    if (wr_fire) ram[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (!reset_n)  rd_data <= '0;
    else if (load) rd_data <= ram[rd_ptr];
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      ram_cnt      <= '0;
      rd_valid     <= 1'b0;
      overflow_err <= 1'b0;
    end else begin
      if (wr_fire) wr_ptr <= ptr_inc(wr_ptr);
      if (load) begin
        rd_ptr   <= ptr_inc(rd_ptr);
        rd_valid <= 1'b1;
      end else if (rd_ready) begin
        rd_valid <= 1'b0;
      end
      case ({wr_fire, load})
        2'b10:   ram_cnt <= ram_cnt + 1'b1;
        2'b01:   ram_cnt <= ram_cnt - 1'b1;
        default: ram_cnt <= ram_cnt;
      endcase
      if (wr_valid & ~wr_ready) overflow_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_dram_fifo_ctl.sv
// Bench for dram_fifo_ctl: vector table for the short sequences, scoreboard
// queue plus a small reference model for fill/stream/full/reset scenarios.
module tb_dram_fifo_ctl;
  localparam int AW = 6;
  localparam int BW = 8;
  localparam int DP = 34;

  logic          clk, reset_n;
  logic          wr_valid, wr_ready, rd_valid, rd_ready, overflow_err;
  logic [BW-1:0] wr_data, rd_data;
  logic [AW:0]   level;

  dram_fifo_ctl #(.ADDRESSWIDTH(AW), .BITWIDTH(BW), .DEPTH(DP)) dut (
    .clk(clk), .reset_n(reset_n),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
    .level(level), .overflow_err(overflow_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0, n_pass = 0;
  int m_cnt = 0;
  bit m_rv = 0, m_ovf = 0;
  logic [BW-1:0] sbq [$];

  typedef struct {
    bit          wv;
    logic [7:0]  wd;
    bit          rr;
    bit          rv;
    int          lvl;
    bit          wrdy;
    logic [7:0]  dat;
  } vec_t;
  vec_t tbl [13];

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", nm, act, act, exp, exp, $time);
  endtask

  // One cycle: check outputs against the model, score pops, advance the model.
  task automatic step(input bit wv, input logic [7:0] wd, input bit rr);
    bit fire, ld;
    logic [BW-1:0] e;
    wr_valid = wv; wr_data = wd; rd_ready = rr;
    #1;
    chk("wr_ready", wr_ready, (m_cnt != DP));
    chk("rd_valid", rd_valid, m_rv);
    chk("level", level, m_cnt + m_rv);
    chk("overflow_err", overflow_err, m_ovf);
    if (m_rv && rr) begin
      if (sbq.size() == 0) chk("sb_empty_pop", 1, 0);
      else begin
        e = sbq.pop_front();
        chk("rd_data", rd_data, e);
      end
    end
    fire = wv && (m_cnt != DP);
    ld   = (m_cnt != 0) && (!m_rv || rr);
    if (wv && !fire) m_ovf = 1;
    if (fire) sbq.push_back(wd);
    m_cnt = m_cnt + int'(fire) - int'(ld);
    if (ld) m_rv = 1;
    else if (rr) m_rv = 0;
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    reset_n = 0; wr_valid = 0; rd_ready = 0; wr_data = '0;
    @(posedge clk); #1;
    reset_n = 1;
    m_cnt = 0; m_rv = 0; m_ovf = 0;
    sbq.delete();
  endtask

  task automatic drain(input int n);
    repeat (n) step(0, 8'h00, 1);
  endtask

  initial begin
    reset_n = 0; wr_valid = 0; rd_ready = 0; wr_data = '0;
    repeat (2) @(posedge clk);
    #1;

    // Reset/idle and single-write vectors (state after each edge).
    for (int i = 0; i < 5; i++) tbl[i] = '{0, 8'h00, 0, 0, 0, 1, 8'h00};
    tbl[5]  = '{1, 8'h01, 0, 0, 1, 1, 8'h00};
    tbl[6]  = '{0, 8'h00, 0, 1, 1, 1, 8'h01};
    tbl[7]  = '{0, 8'h00, 0, 1, 1, 1, 8'h01};
    tbl[8]  = '{0, 8'h00, 1, 0, 0, 1, 8'h01};
    tbl[9]  = '{0, 8'h00, 1, 0, 0, 1, 8'h01};
    tbl[10] = '{1, 8'h3C, 1, 0, 1, 1, 8'h01};
    tbl[11] = '{0, 8'h00, 1, 1, 1, 1, 8'h3C};
    tbl[12] = '{0, 8'h00, 1, 0, 0, 1, 8'h3C};
    do_reset();
    chk("rst_rd_valid", rd_valid, 0);
    chk("rst_level", level, 0);
    for (int i = 0; i < 13; i++) begin
      wr_valid = tbl[i].wv; wr_data = tbl[i].wd; rd_ready = tbl[i].rr;
      @(posedge clk); #1;
      chk($sformatf("vec%0d_rd_valid", i), rd_valid, tbl[i].rv);
      chk($sformatf("vec%0d_level", i), level, tbl[i].lvl);
      chk($sformatf("vec%0d_wr_ready", i), wr_ready, tbl[i].wrdy);
      chk($sformatf("vec%0d_rd_data", i), rd_data, tbl[i].dat);
      chk($sformatf("vec%0d_overflow", i), overflow_err, 0);
    end

    // Fill to DEPTH+1, overflow on one more, drain in order across the wrap.
    do_reset();
    chk("fill_rst_rd_data", rd_data, 0);
    for (int i = 0; i <= DP; i++) step(1, 8'(i), 0);
    chk("full_level", level, DP + 1);
    chk("full_wr_ready", wr_ready, 0);
    step(1, 8'hFF, 0);
    chk("ovf_set", overflow_err, 1);
    chk("ovf_level_held", level, DP + 1);
    drain(DP + 4);
    chk("drained_level", level, 0);

    // Back-to-back streaming.
    do_reset();
    for (int k = 0; k < 200; k++) begin
      if (k >= 2) begin
        chk("stream_valid", rd_valid, 1);
        chk("stream_level_rng", int'(level >= 1 && level <= 2), 1);
      end
      step(1, 8'(k), 1);
    end
    drain(4);

    // Full RAM with a pop: write held off that cycle, accepted the next.
    do_reset();
    for (int i = 0; i <= DP; i++) step(1, 8'(8'h40 + i), 0);
    step(1, 8'hEE, 1);
    chk("after_pop_wr_ready", wr_ready, 1);
    chk("after_pop_level", level, DP);
    step(1, 8'h77, 0);
    chk("refill_level", level, DP + 1);
    drain(DP + 4);

    // Mid-operation reset discards contents and the sticky error.
    for (int i = 0; i < 20; i++) step(1, 8'(8'h90 + i), 0);
    step(0, 8'h00, 0);
    chk("pre_rst_level", level, 20);
    chk("pre_rst_ovf", overflow_err, 1);
    do_reset();
    chk("mid_rst_level", level, 0);
    chk("mid_rst_rd_valid", rd_valid, 0);
    chk("mid_rst_ovf", overflow_err, 0);
    chk("mid_rst_wr_ready", wr_ready, 1);
    step(1, 8'hA5, 0);
    step(1, 8'h5A, 0);
    step(0, 8'h00, 0);
    chk("post_rst_head", rd_data, 8'hA5);
    drain(5);
    chk("post_rst_empty", level, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end
endmodule
